// File: rtl/flow_aging_scheduler_pkg.sv
// Shared types and helpers for the flow aging scheduler: FSM state encoding,
// stored etime width and the expiry compare used by the scanner.
package flow_aging_scheduler_pkg;

    // Width of a stored expiry time; matches the etime RAM data width.
    localparam int EXP_TIME_NBITS = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_INT = 3'd1,
        ST_RD       = 3'd2,
        ST_ACK      = 3'd3,
        ST_CMP      = 3'd4,
        ST_DEL      = 3'd5,
        ST_NEXT     = 3'd6
    } aging_state_e;

    // Modular age compare; an etime of zero marks an unused entry.
    function automatic logic is_expired(
        input logic [EXP_TIME_NBITS-1:0] now,
        input logic [EXP_TIME_NBITS-1:0] etime,
        input logic [EXP_TIME_NBITS-1:0] timeout
    );
        logic [EXP_TIME_NBITS-1:0] age;
        age = now - etime;
        return (etime != {EXP_TIME_NBITS{1'b0}}) && (age > timeout);
    endfunction

endpackage

// File: rtl/flow_etime_rd_arb.sv
// Strict-priority read-port arbiter for the flow etime RAM. The lookup path always
// wins; the owner register steers the one-cycle-later ack back to its requester.
module flow_etime_rd_arb #(
    parameter int ADDR_NBITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_lkp_rd,
    input  logic [ADDR_NBITS-1:0] i_lkp_raddr,
    input  logic                  i_scan_rd,
    input  logic [ADDR_NBITS-1:0] i_scan_raddr,
    input  logic                  i_ram_ack,
    output logic                  o_ram_rd,
    output logic [ADDR_NBITS-1:0] o_ram_raddr,
    output logic                  o_scan_grant,
    output logic                  o_lkp_ack,
    output logic                  o_scan_ack
);

    logic r_owner_lkp;

    // Record which requester owns the read issued this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner_lkp <= 1'b0;
        end else begin
            r_owner_lkp <= i_lkp_rd;
        end
    end

    assign o_scan_grant = i_scan_rd & ~i_lkp_rd;
    assign o_ram_rd     = i_lkp_rd | o_scan_grant;
    assign o_ram_raddr  = i_lkp_rd ? i_lkp_raddr : i_scan_raddr;
    assign o_lkp_ack    = i_ram_ack & r_owner_lkp;
    assign o_scan_ack   = i_ram_ack & ~r_owner_lkp;

endmodule

// File: rtl/flow_aging_scheduler.sv
// Shares the etime RAM read port between lookups and a background aging scanner
// that issues delete requests for expired flows. Optional statistics counters are
// built when FLOW_AGING_STATS_EN is defined.
module flow_aging_scheduler
    import flow_aging_scheduler_pkg::*;
#(
    parameter int VALUE_DEPTH_NBITS = 4,
    parameter int REAL_TIME_NBITS   = 32,
    parameter int INTERVAL_NBITS    = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_aging_en,
    input  logic [EXP_TIME_NBITS-1:0]    cfg_timeout,
    input  logic [INTERVAL_NBITS-1:0]    cfg_scan_interval,
    input  logic [REAL_TIME_NBITS-1:0]   current_time,
    input  logic                         lkp_etime_rd,
    input  logic [VALUE_DEPTH_NBITS-1:0] lkp_etime_raddr,
    output logic                         lkp_etime_ack,
    output logic [EXP_TIME_NBITS-1:0]    lkp_etime_rdata,
    output logic                         flow_etime_rd,
    output logic [VALUE_DEPTH_NBITS-1:0] flow_etime_raddr,
    input  logic                         flow_etime_ack,
    input  logic [EXP_TIME_NBITS-1:0]    flow_etime_rdata,
    output logic                         aging_del_valid,
    output logic [VALUE_DEPTH_NBITS-1:0] aging_del_fid,
    input  logic                         aging_del_ready,
`ifdef FLOW_AGING_STATS_EN
    output logic [31:0]                  stat_del_cnt,
    output logic [31:0]                  stat_stall_cnt,
    output logic [15:0]                  stat_pass_cnt,
`endif
    output logic                         scan_done
);

    aging_state_e                 r_state;
    aging_state_e                 w_next_state;
    logic [VALUE_DEPTH_NBITS-1:0] r_scan_ptr;
    logic [INTERVAL_NBITS-1:0]    r_int_cnt;
    logic [EXP_TIME_NBITS-1:0]    r_etime;
    logic                         w_scan_req;
    logic                         w_scan_grant;
    logic                         w_scan_ack;
    logic                         w_ptr_last;
    logic                         w_expired;
    logic [EXP_TIME_NBITS-1:0]    w_now;

    flow_etime_rd_arb #(
        .ADDR_NBITS (VALUE_DEPTH_NBITS)
    ) u_rd_arb (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_lkp_rd     (lkp_etime_rd),
        .i_lkp_raddr  (lkp_etime_raddr),
        .i_scan_rd    (w_scan_req),
        .i_scan_raddr (r_scan_ptr),
        .i_ram_ack    (flow_etime_ack),
        .o_ram_rd     (flow_etime_rd),
        .o_ram_raddr  (flow_etime_raddr),
        .o_scan_grant (w_scan_grant),
        .o_lkp_ack    (lkp_etime_ack),
        .o_scan_ack   (w_scan_ack)
    );

    assign lkp_etime_rdata = flow_etime_rdata;
    assign w_now           = current_time[REAL_TIME_NBITS-1 -: EXP_TIME_NBITS];
    assign w_ptr_last      = &r_scan_ptr;
    assign w_expired       = is_expired(w_now, r_etime, cfg_timeout);

    // Scanner next-state logic; a disable only takes effect between entries.
    always_comb begin
        w_next_state = r_state;
        w_scan_req   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cfg_aging_en) w_next_state = ST_WAIT_INT;
                else              w_next_state = ST_IDLE;
            end
            ST_WAIT_INT: begin
                if (!cfg_aging_en)                          w_next_state = ST_IDLE;
                else if (r_int_cnt == {INTERVAL_NBITS{1'b0}}) w_next_state = ST_RD;
                else                                        w_next_state = ST_WAIT_INT;
            end
            ST_RD: begin
                w_scan_req = 1'b1;
                if (w_scan_grant) w_next_state = ST_ACK;
                else              w_next_state = ST_RD;
            end
            ST_ACK: begin
                if (w_scan_ack) w_next_state = ST_CMP;
                else            w_next_state = ST_ACK;
            end
            ST_CMP: begin
                if (w_expired) w_next_state = ST_DEL;
                else           w_next_state = ST_NEXT;
            end
            ST_DEL: begin
                if (aging_del_ready) w_next_state = ST_NEXT;
                else                 w_next_state = ST_DEL;
            end
            ST_NEXT: begin
                if (w_ptr_last)        w_next_state = ST_IDLE;
                else if (cfg_aging_en) w_next_state = ST_RD;
                else                   w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Scanner state, pointer, interval counter and latched etime.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_scan_ptr <= {VALUE_DEPTH_NBITS{1'b0}};
            r_int_cnt  <= {INTERVAL_NBITS{1'b0}};
            r_etime    <= {EXP_TIME_NBITS{1'b0}};
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_IDLE && cfg_aging_en) begin
                r_int_cnt <= cfg_scan_interval;
            end else if (r_state == ST_WAIT_INT && r_int_cnt != {INTERVAL_NBITS{1'b0}}) begin
                r_int_cnt <= r_int_cnt - {{(INTERVAL_NBITS-1){1'b0}}, 1'b1};
            end
            // Natural overflow wraps the pointer to entry 0 after the last entry.
            if (r_state == ST_NEXT) begin
                r_scan_ptr <= r_scan_ptr + {{(VALUE_DEPTH_NBITS-1){1'b0}}, 1'b1};
            end
            if (r_state == ST_ACK && w_scan_ack) begin
                r_etime <= flow_etime_rdata;
            end
        end
    end

    assign aging_del_valid = (r_state == ST_DEL);
    assign aging_del_fid   = r_scan_ptr;
    assign scan_done       = (r_state == ST_NEXT) && w_ptr_last;

`ifdef FLOW_AGING_STATS_EN
    logic [31:0] r_del_cnt;
    logic [31:0] r_stall_cnt;
    logic [15:0] r_pass_cnt;

    // Saturating event counters for deletes, RD stalls and completed passes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_del_cnt   <= 32'd0;
            r_stall_cnt <= 32'd0;
            r_pass_cnt  <= 16'd0;
        end else begin
            if (aging_del_valid && aging_del_ready && r_del_cnt != 32'hFFFF_FFFF) begin
                r_del_cnt <= r_del_cnt + 32'd1;
            end
            if (r_state == ST_RD && !w_scan_grant && r_stall_cnt != 32'hFFFF_FFFF) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (scan_done && r_pass_cnt != 16'hFFFF) begin
                r_pass_cnt <= r_pass_cnt + 16'd1;
            end
        end
    end

    assign stat_del_cnt   = r_del_cnt;
    assign stat_stall_cnt = r_stall_cnt;
    assign stat_pass_cnt  = r_pass_cnt;
`endif

endmodule

// File: tb/tb_flow_aging_scheduler.sv
// Directed self-checking bench for flow_aging_scheduler with a 16-entry etime RAM model.
module tb_flow_aging_scheduler;
    import flow_aging_scheduler_pkg::*;

    localparam int AW = 4;
    localparam int TW = 32;
    localparam int IW = 16;

    logic                      clk;
    logic                      rst_n;
    logic                      cfg_aging_en;
    logic [EXP_TIME_NBITS-1:0] cfg_timeout;
    logic [IW-1:0]             cfg_scan_interval;
    logic [TW-1:0]             current_time;
    logic                      lkp_etime_rd;
    logic [AW-1:0]             lkp_etime_raddr;
    logic                      lkp_etime_ack;
    logic [EXP_TIME_NBITS-1:0] lkp_etime_rdata;
    logic                      flow_etime_rd;
    logic [AW-1:0]             flow_etime_raddr;
    logic                      flow_etime_ack;
    logic [EXP_TIME_NBITS-1:0] flow_etime_rdata;
    logic                      aging_del_valid;
    logic [AW-1:0]             aging_del_fid;
    logic                      aging_del_ready;
    logic                      scan_done;

    logic [EXP_TIME_NBITS-1:0] mem [16];
    int                        checks;
    int                        errors;
    int                        del_cnt;
    int                        scan_rd_cnt;
    logic [AW-1:0]             last_fid;

    flow_aging_scheduler #(
        .VALUE_DEPTH_NBITS (AW),
        .REAL_TIME_NBITS   (TW),
        .INTERVAL_NBITS    (IW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cfg_aging_en      (cfg_aging_en),
        .cfg_timeout       (cfg_timeout),
        .cfg_scan_interval (cfg_scan_interval),
        .current_time      (current_time),
        .lkp_etime_rd      (lkp_etime_rd),
        .lkp_etime_raddr   (lkp_etime_raddr),
        .lkp_etime_ack     (lkp_etime_ack),
        .lkp_etime_rdata   (lkp_etime_rdata),
        .flow_etime_rd     (flow_etime_rd),
        .flow_etime_raddr  (flow_etime_raddr),
        .flow_etime_ack    (flow_etime_ack),
        .flow_etime_rdata  (flow_etime_rdata),
        .aging_del_valid   (aging_del_valid),
        .aging_del_fid     (aging_del_fid),
        .aging_del_ready   (aging_del_ready),
        .scan_done         (scan_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Etime RAM model: data and ack one cycle after the read strobe.
    always @(posedge clk) begin
        flow_etime_ack   <= flow_etime_rd;
        flow_etime_rdata <= mem[flow_etime_raddr];
    end

    // Observe delete handshakes and scanner-issued reads.
    always @(negedge clk) begin
        if (aging_del_valid && aging_del_ready) begin
            del_cnt  = del_cnt + 1;
            last_fid = aging_del_fid;
        end
        if (flow_etime_rd && !lkp_etime_rd) scan_rd_cnt = scan_rd_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n             = 1'b0;
        cfg_aging_en      = 1'b0;
        cfg_timeout       = 16'h0010;
        cfg_scan_interval = 16'd0;
        current_time      = 32'h0030_0000;
        lkp_etime_rd      = 1'b0;
        lkp_etime_raddr   = 4'd0;
        aging_del_ready   = 1'b1;
        for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (scan_done) seen = 1'b1;
        end
        check_eq(tag, {31'd0, seen}, 32'd1);
    endtask

    task automatic wait_del(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (aging_del_valid) seen = 1'b1;
        end
        check_eq(tag, {31'd0, seen}, 32'd1);
    endtask

    // Run one full pass from reset and return the number of deletes issued.
    task automatic run_pass(input logic [15:0] now, input logic [15:0] tmo, output int dels);
        int base;
        @(posedge clk); #1;
        current_time = {now, 16'h0000};
        cfg_timeout  = tmo;
        base         = del_cnt;
        cfg_aging_en = 1'b1;
        wait_done("pass_done");
        @(posedge clk); #1 cfg_aging_en = 1'b0;
        repeat (3) @(negedge clk);
        dels = del_cnt - base;
    endtask

    initial begin
        int base;
        int dels;
        int gap;
        logic seen;
        logic [AW-1:0] cur;
        logic [AW-1:0] prev;
        checks      = 0;
        errors      = 0;
        del_cnt     = 0;
        scan_rd_cnt = 0;
        last_fid    = '0;

        // Outputs while reset is held.
        rst_n = 1'b0; cfg_aging_en = 1'b0; lkp_etime_rd = 1'b0; lkp_etime_raddr = 4'd0;
        aging_del_ready = 1'b1; cfg_timeout = 16'h0; cfg_scan_interval = 16'd0;
        current_time = 32'h0;
        @(negedge clk);
        check_eq("rst_del_valid", {31'd0, aging_del_valid}, 32'd0);
        check_eq("rst_del_fid", {28'd0, aging_del_fid}, 32'd0);
        check_eq("rst_scan_done", {31'd0, scan_done}, 32'd0);
        check_eq("rst_ram_rd", {31'd0, flow_etime_rd}, 32'd0);

        // Single expired entry, interval 4, pass wrap and restart gap.
        do_reset();
        mem[5] = 16'h0010;
        mem[3] = 16'h0028;
        mem[9] = 16'h0020;
        cfg_scan_interval = 16'd4;
        base = del_cnt;
        cfg_aging_en = 1'b1;
        wait_done("t1_done");
        gap  = 0;
        seen = 1'b0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            if (flow_etime_rd && !lkp_etime_rd) begin
                seen = 1'b1;
                gap  = i;
                check_eq("t1_wrap_addr", {28'd0, flow_etime_raddr}, 32'd0);
            end
        end
        check_eq("t1_restart_gap", gap, 32'd7);
        check_eq("t1_del_count", del_cnt - base, 32'd1);
        check_eq("t1_del_fid", {28'd0, last_fid}, 32'd5);

        // Lookups held for 50 cycles starve the scanner without extra latency.
        do_reset();
        for (int i = 0; i < 16; i++) mem[i] = 16'h0100 + 16'(i);
        cfg_timeout = 16'hFFFF;
        cfg_aging_en = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        lkp_etime_rd    = 1'b1;
        cur             = 4'd0;
        lkp_etime_raddr = cur;
        base            = scan_rd_cnt;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #1;
            prev = cur;
            check_eq("t2_lkp_ack", {31'd0, lkp_etime_ack}, 32'd1);
            check_eq("t2_lkp_data", {16'd0, lkp_etime_rdata}, {16'd0, mem[prev]});
            cur             = cur + 4'd3;
            lkp_etime_raddr = cur;
        end
        lkp_etime_rd = 1'b0;
        check_eq("t2_scan_reads", scan_rd_cnt - base, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            @(negedge clk);
            if (flow_etime_rd) seen = 1'b1;
        end
        check_eq("t2_scan_resume", {31'd0, seen}, 32'd1);
        check_eq("t2_no_del", {31'd0, aging_del_valid}, 32'd0);

        // Delete held by backpressure for 10 cycles.
        do_reset();
        mem[2] = 16'h0010;
        aging_del_ready = 1'b0;
        cfg_aging_en = 1'b1;
        wait_del("t3_del_seen");
        base = scan_rd_cnt;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check_eq("t3_hold_valid", {31'd0, aging_del_valid}, 32'd1);
            check_eq("t3_hold_fid", {28'd0, aging_del_fid}, 32'd2);
        end
        check_eq("t3_no_advance", scan_rd_cnt - base, 32'd0);
        base = del_cnt;
        @(posedge clk); #1 aging_del_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("t3_one_del", del_cnt - base, 32'd1);
        check_eq("t3_valid_drop", {31'd0, aging_del_valid}, 32'd0);

        // Time wrap in etime units, and an all-ones timeout.
        do_reset();
        mem[1] = 16'hFFF0;
        run_pass(16'h0005, 16'h0010, dels);
        check_eq("t4_wrap_del", dels, 32'd1);
        check_eq("t4_wrap_fid", {28'd0, last_fid}, 32'd1);
        do_reset();
        mem[1] = 16'hFFF0;
        run_pass(16'h0005, 16'h0020, dels);
        check_eq("t4_wrap_keep", dels, 32'd0);
        do_reset();
        mem[4] = 16'h0001;
        run_pass(16'h0000, 16'hFFFF, dels);
        check_eq("t4_tmo_max", dels, 32'd0);

        // Disable during a pending delete at entry 7, then resume at entry 8.
        do_reset();
        mem[7] = 16'h0010;
        aging_del_ready = 1'b0;
        cfg_aging_en = 1'b1;
        wait_del("t5_del_seen");
        check_eq("t5_del_fid", {28'd0, aging_del_fid}, 32'd7);
        @(posedge clk); #1 cfg_aging_en = 1'b0;
        repeat (3) @(posedge clk);
        base = del_cnt;
        #1 aging_del_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("t5_del_done", del_cnt - base, 32'd1);
        base = scan_rd_cnt;
        repeat (20) @(negedge clk);
        check_eq("t5_idle", scan_rd_cnt - base, 32'd0);
        @(posedge clk); #1 cfg_aging_en = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (flow_etime_rd) begin
                seen = 1'b1;
                check_eq("t5_resume_addr", {28'd0, flow_etime_raddr}, 32'd8);
            end
        end
        check_eq("t5_resumed", {31'd0, seen}, 32'd1);

        // Reset asserted while a delete is pending drops it at once.
        do_reset();
        mem[0] = 16'h0010;
        aging_del_ready = 1'b0;
        cfg_aging_en = 1'b1;
        wait_del("t6_del_seen");
        #2 rst_n = 1'b0;
        #1;
        check_eq("t6_rst_drop", {31'd0, aging_del_valid}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/flow_aging_scheduler.md
Name: flow_aging_scheduler

Overview:
- Shares the flow expiry-time (etime) memory read port between classifier lookups and a background aging scanner.
- The scanner walks every flow ID, compares stored etime against current time, and issues delete requests for expired flows toward the flow-table maintenance logic.
- Sits between classifier lookup logic and the flow etime RAM inside the classifier flow memory subsystem.

Parameters:
- VALUE_DEPTH_NBITS, `FLOW_VALUE_DEPTH_NBITS: log2 of etime entries; the FID indexes etime directly.
- EXP_TIME_NBITS, `EXP_TIME_NBITS: stored etime width.
- REAL_TIME_NBITS, `REAL_TIME_NBITS: free-running time width.
- INTERVAL_NBITS, 16: width of the idle gap counter between scan passes.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_aging_en  in  1  enable scanner
- cfg_timeout  in  EXP_TIME_NBITS  age threshold, in etime units
- cfg_scan_interval  in  INTERVAL_NBITS  idle cycles between passes
- current_time  in  REAL_TIME_NBITS  free-running time
- lkp_etime_rd  in  1  lookup read strobe (no backpressure)
- lkp_etime_raddr  in  VALUE_DEPTH_NBITS  lookup address
- lkp_etime_ack  out  1  lookup data valid
- lkp_etime_rdata  out  EXP_TIME_NBITS  lookup data
- flow_etime_rd  out  1  RAM read strobe
- flow_etime_raddr  out  VALUE_DEPTH_NBITS  RAM address
- flow_etime_ack  in  1  RAM ack, 1 cycle after rd
- flow_etime_rdata  in  EXP_TIME_NBITS  RAM data
- aging_del_valid  out  1  delete request
- aging_del_fid  out  VALUE_DEPTH_NBITS  FID to delete
- aging_del_ready  in  1  consumer accepts
- scan_done  out  1  one-cycle pulse at end of pass

Behaviour:
- Reset: all outputs 0. FSM in IDLE; scan pointer, interval counter and owner register cleared.
- Arbitration:
  - Lookup has strict priority.
  - flow_etime_rd = lkp_etime_rd | scan_rd_grant, where scan_rd_grant = scanner wants read & ~lkp_etime_rd.
  - flow_etime_raddr is registered-free mux (combinational) selecting the lookup address when lkp_etime_rd.
  - Read ownership register: owner_lkp <= lkp_etime_rd, captured every cycle.
  - lkp_etime_ack = flow_etime_ack & owner_lkp.
  - lkp_etime_rdata = flow_etime_rdata, passed through.
  - Lookup latency is exactly 1 cycle, unchanged by the scanner.
- FSM states:
  - IDLE: when cfg_aging_en=1, load interval counter with cfg_scan_interval, then go to WAIT_INT.
  - WAIT_INT: decrement the counter each cycle. At 0, go to RD. If cfg_aging_en drops, return to IDLE.
  - RD: request a read at scan_ptr. On grant, go to ACK; otherwise stay in RD (stall).
  - ACK: wait for flow_etime_ack with owner_lkp=0. Latch etime, go to CMP.
  - CMP:
    - now = current_time[REAL_TIME_NBITS-1 -: EXP_TIME_NBITS].
    - age = (now - etime) mod 2^EXP_TIME_NBITS.
    - Expired iff etime != 0 and age > cfg_timeout.
    - If expired, go to DEL; else go to NEXT.
  - DEL: hold aging_del_valid=1 with aging_del_fid=scan_ptr until aging_del_ready, then go to NEXT. valid and fid are stable while waiting.
  - NEXT:
    - If scan_ptr is all-ones: pulse scan_done, wrap scan_ptr to 0, go to IDLE.
    - Else increment scan_ptr and go to RD.
- Boundaries:
  - Entry 0 is scanned; etime 0 means unused and is never deleted.
  - Time wrap is handled by the modular subtraction.
  - cfg_timeout = all-ones: nothing expires.
  - cfg_aging_en deasserted mid-pass: finish the current entry (including a pending DEL), then go to IDLE. scan_ptr is retained, so the next pass resumes there.
  - cfg_scan_interval = 0: RD is entered after one WAIT_INT cycle.
  - Reset mid-DEL: the request is dropped immediately.

Optional Feature:
- FLOW_AGING_STATS_EN adds output ports:
  - stat_del_cnt, 32 bits: increments on each del handshake.
  - stat_stall_cnt, 32 bits: increments each cycle in RD without a grant.
  - stat_pass_cnt, 16 bits: increments on scan_done.
- All counters saturate and reset to 0.
- Without the macro, these ports and counters do not exist.

Decomposition:
- Shared package:
  - FSM state enum (IDLE, WAIT_INT, RD, ACK, CMP, DEL, NEXT).
  - Aging compare function, with EXP_TIME_NBITS taken from defines.vh.
- One sub-module, flow_etime_rd_arb: the priority mux plus the owner register, so the arbiter can be reused by other etime readers.

Test Plan:
- Etime[5]=0x10, now=0x30, timeout=0x10 -> aging_del_valid with fid=5; no other deletes in the pass.
- lkp_etime_rd held high for 50 cycles during a scan -> lookup ack every cycle at 1-cycle latency; scanner stalls in RD, with zero scanner reads issued.
- aging_del_ready low for 10 cycles -> valid and fid stable; scan_ptr does not advance; one delete after ready.
- Etime=0xFFF0, now=0x0005 (16-bit), timeout=0x10 -> age 0x15, deleted; timeout=0x20 -> not deleted.
- Depth 16, cfg_scan_interval=4 -> scan_done after entry 15, scan_ptr wraps to 0; next pass starts exactly after 4 idle cycles.
- Deassert cfg_aging_en at entry 7 with a pending DEL -> delete completes, FSM goes to IDLE; re-enable resumes at entry 8.
